control_fsm: RTL and testbench

Multicycle main control unit for the 16-bit processor. Sequences each instruction through fetch, decode, execute, memory and writeback states, driving the ALU-control inputs (opcode, shift-type, force-add) and all datapath enables. Runs a request/acknowledge handshake with instruction/data memory. Sits between the instruction register and the datapath; its `Out_Inst`, `Out_Si` and `Out_PerformAddition` feed the ALU control decoder directly.

---
 rtl/control_fsm_pkg.sv | 55 +++++
 rtl/control_decode.sv | 25 ++
 rtl/control_fsm.sv | 172 +++++++++++++++++
 tb/tb_control_fsm.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_fsm_pkg.sv
// Shared definitions for the multicycle control unit: opcodes, ALUSrcB selects,
// FSM state encoding and the opcode dispatch classes.
package control_fsm_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_ADDI  = 4'b0100;
    localparam logic [3:0] OP_SHIFT = 4'b0101;
    localparam logic [3:0] OP_RSV6  = 4'b0110;
    localparam logic [3:0] OP_LW    = 4'b0111;
    localparam logic [3:0] OP_SW    = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1001;
    localparam logic [3:0] OP_RSVA  = 4'b1010;
    localparam logic [3:0] OP_RSVB  = 4'b1011;
    localparam logic [3:0] OP_JAL   = 4'b1100;
    localparam logic [3:0] OP_JALR  = 4'b1101;
    localparam logic [3:0] OP_LUI   = 4'b1110;
    localparam logic [3:0] OP_LBI   = 4'b1111;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_TWO   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_SHIMM = 2'b11;

    typedef enum logic [3:0] {
        S_INIT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_ALU_WB,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_EXEC,
        CLS_ADDR,
        CLS_BRANCH,
        CLS_JUMP,
        CLS_ILLEGAL
    } op_class_e;

    // ALU ops whose second operand is the sign-extended immediate.
    function automatic logic is_imm_alu(input logic [3:0] op);
        return (op == OP_ADDI) || (op == OP_LUI) || (op == OP_LBI);
    endfunction

endpackage

// File: rtl/control_decode.sv
// Combinational opcode classifier: dispatch class for DECODE and the
// ALUSrcB select used in EXEC.
module control_decode
    import control_fsm_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_e  op_class,
    output logic [1:0] exec_srcb
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ADDI, OP_SHIFT, OP_LUI, OP_LBI: op_class = CLS_EXEC;
            OP_LW, OP_SW:                      op_class = CLS_ADDR;
            OP_BEQ:                            op_class = CLS_BRANCH;
            OP_JAL, OP_JALR:                   op_class = CLS_JUMP;
            default:                           op_class = CLS_ILLEGAL;
        endcase
    end

    assign exec_srcb = is_imm_alu(opcode) ? SRCB_IMM : SRCB_REG;

endmodule

// File: rtl/control_fsm.sv
// Multicycle main control FSM for the 16-bit processor.
// Define CONTROL_ILLEGAL_TRAP_EN to halt with a sticky flag on illegal opcodes.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int INSTR_W = 16
) (
    input  logic               CLK,
    input  logic               Reset_N,
    input  logic [INSTR_W-1:0] In_Instr,
    input  logic               In_MemAck,
    input  logic               In_Zero,
    output logic               Out_MemReq,
    output logic               Out_MemRead,
    output logic               Out_MemWrite,
    output logic               Out_IorD,
    output logic               Out_IRWrite,
    output logic               Out_PCWrite,
    output logic               Out_PCWriteCond,
    output logic               Out_RegWrite,
    output logic               Out_MemToReg,
    output logic               Out_ALUSrcA,
    output logic [1:0]         Out_ALUSrcB,
    output logic [3:0]         Out_Inst,
    output logic [1:0]         Out_Si,
    output logic               Out_PerformAddition,
    output logic               Out_Illegal
);

    state_e     state_reg;
    logic [3:0] inst_reg;
    logic [1:0] si_reg;
    op_class_e  op_class;
    logic [1:0] exec_srcb;

    // The zero flag gates the PC load inside the datapath, not here.
    logic unused_inputs;
    assign unused_inputs = ^{In_Instr[INSTR_W-5:2], In_Zero};

    control_decode u_decode (
        .opcode    (inst_reg),
        .op_class  (op_class),
        .exec_srcb (exec_srcb)
    );

`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic illegal_reg;
    assign Out_Illegal = illegal_reg;
`else
    assign Out_Illegal = 1'b0;
`endif

    // Opcode/shift type are captured on the fetch ack so they are valid throughout DECODE.
    always_ff @(posedge CLK or negedge Reset_N) begin
        if (!Reset_N) begin
            state_reg   <= S_INIT;
            inst_reg    <= '0;
            si_reg      <= '0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
            illegal_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                S_INIT:   state_reg <= S_FETCH;
                S_FETCH: begin
                    if (In_MemAck) begin
                        inst_reg  <= In_Instr[INSTR_W-1 -: 4];
                        si_reg    <= In_Instr[1:0];
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op_class)
                        CLS_EXEC:   state_reg <= S_EXEC;
                        CLS_ADDR:   state_reg <= S_ADDR;
                        CLS_BRANCH: state_reg <= S_BRANCH;
                        CLS_JUMP:   state_reg <= S_JUMP;
                        default: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                            illegal_reg <= 1'b1;
                            state_reg   <= S_HALT;
`else
                            state_reg   <= S_FETCH;
`endif
                        end
                    endcase
                end
                S_EXEC:   state_reg <= S_ALU_WB;
                S_ALU_WB: state_reg <= S_FETCH;
                S_ADDR:   state_reg <= (inst_reg == OP_LW) ? S_MEM_RD : S_MEM_WR;
                S_MEM_RD: if (In_MemAck) state_reg <= S_MEM_WB;
                S_MEM_WB: state_reg <= S_FETCH;
                S_MEM_WR: if (In_MemAck) state_reg <= S_FETCH;
                S_BRANCH: state_reg <= S_FETCH;
                S_JUMP:   state_reg <= S_FETCH;
                S_HALT:   state_reg <= S_HALT;
                default:  state_reg <= S_INIT;
            endcase
        end
    end

    assign Out_Inst = inst_reg;
    assign Out_Si   = si_reg;

    always_comb begin
        Out_MemReq          = 1'b0;
        Out_MemRead         = 1'b0;
        Out_MemWrite        = 1'b0;
        Out_IorD            = 1'b0;
        Out_IRWrite         = 1'b0;
        Out_PCWrite         = 1'b0;
        Out_PCWriteCond     = 1'b0;
        Out_RegWrite        = 1'b0;
        Out_MemToReg        = 1'b0;
        Out_ALUSrcA         = 1'b0;
        Out_ALUSrcB         = SRCB_REG;
        Out_PerformAddition = 1'b0;
        case (state_reg)
            S_FETCH: begin
                Out_MemReq  = 1'b1;
                Out_MemRead = 1'b1;
                if (In_MemAck) begin
                    Out_IRWrite         = 1'b1;
                    Out_PCWrite         = 1'b1;
                    Out_PerformAddition = 1'b1;
                    Out_ALUSrcB         = SRCB_TWO;
                end
            end
            S_DECODE: begin
                Out_PerformAddition = 1'b1;
                Out_ALUSrcB         = SRCB_SHIMM;
            end
            S_EXEC: begin
                Out_ALUSrcA = 1'b1;
                Out_ALUSrcB = exec_srcb;
            end
            S_ALU_WB: Out_RegWrite = 1'b1;
            S_ADDR: begin
                Out_PerformAddition = 1'b1;
                Out_ALUSrcA         = 1'b1;
                Out_ALUSrcB         = SRCB_IMM;
            end
            S_MEM_RD: begin
                Out_MemReq  = 1'b1;
                Out_MemRead = 1'b1;
                Out_IorD    = 1'b1;
            end
            S_MEM_WB: begin
                Out_RegWrite = 1'b1;
                Out_MemToReg = 1'b1;
            end
            S_MEM_WR: begin
                Out_MemReq   = 1'b1;
                Out_MemWrite = 1'b1;
                Out_IorD     = 1'b1;
            end
            // Out_Inst already holds the BEQ opcode, which the ALU decoder maps to SUB.
            S_BRANCH: begin
                Out_ALUSrcA     = 1'b1;
                Out_PCWriteCond = 1'b1;
            end
            S_JUMP: begin
                Out_PCWrite         = 1'b1;
                Out_RegWrite        = 1'b1;
                Out_PerformAddition = 1'b1;
                Out_ALUSrcA         = (inst_reg == OP_JALR);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_fsm.sv
// Directed-vector bench for control_fsm: each cycle drives memory inputs and
// compares the control word, latched opcode/shift type and illegal flag.
module tb_control_fsm;

    logic        CLK;
    logic        Reset_N;
    logic [15:0] In_Instr;
    logic        In_MemAck;
    logic        In_Zero;
    logic        Out_MemReq, Out_MemRead, Out_MemWrite, Out_IorD;
    logic        Out_IRWrite, Out_PCWrite, Out_PCWriteCond, Out_RegWrite;
    logic        Out_MemToReg, Out_ALUSrcA, Out_PerformAddition, Out_Illegal;
    logic [1:0]  Out_ALUSrcB;
    logic [3:0]  Out_Inst;
    logic [1:0]  Out_Si;

    control_fsm #(.INSTR_W(16)) dut (
        .CLK                 (CLK),
        .Reset_N             (Reset_N),
        .In_Instr            (In_Instr),
        .In_MemAck           (In_MemAck),
        .In_Zero             (In_Zero),
        .Out_MemReq          (Out_MemReq),
        .Out_MemRead         (Out_MemRead),
        .Out_MemWrite        (Out_MemWrite),
        .Out_IorD            (Out_IorD),
        .Out_IRWrite         (Out_IRWrite),
        .Out_PCWrite         (Out_PCWrite),
        .Out_PCWriteCond     (Out_PCWriteCond),
        .Out_RegWrite        (Out_RegWrite),
        .Out_MemToReg        (Out_MemToReg),
        .Out_ALUSrcA         (Out_ALUSrcA),
        .Out_ALUSrcB         (Out_ALUSrcB),
        .Out_Inst            (Out_Inst),
        .Out_Si              (Out_Si),
        .Out_PerformAddition (Out_PerformAddition),
        .Out_Illegal         (Out_Illegal)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Control word: {req, rd, wr, iord, irw, pcw, pcwc, regw, m2r, srca, srcb[1:0], padd}
    logic [12:0] ctrl;
    assign ctrl = {Out_MemReq, Out_MemRead, Out_MemWrite, Out_IorD, Out_IRWrite,
                   Out_PCWrite, Out_PCWriteCond, Out_RegWrite, Out_MemToReg,
                   Out_ALUSrcA, Out_ALUSrcB, Out_PerformAddition};

    localparam logic [12:0] C_IDLE = 13'b0000000000000;
    localparam logic [12:0] C_FW   = 13'b1100000000000;
    localparam logic [12:0] C_FA   = 13'b1100110000011;
    localparam logic [12:0] C_DEC  = 13'b0000000000111;
    localparam logic [12:0] C_EXR  = 13'b0000000001000;
    localparam logic [12:0] C_EXI  = 13'b0000000001100;
    localparam logic [12:0] C_AWB  = 13'b0000000100000;
    localparam logic [12:0] C_ADDR = 13'b0000000001101;
    localparam logic [12:0] C_MRD  = 13'b1101000000000;
    localparam logic [12:0] C_MWB  = 13'b0000000110000;
    localparam logic [12:0] C_MWR  = 13'b1011000000000;
    localparam logic [12:0] C_BR   = 13'b0000001001000;
    localparam logic [12:0] C_JAL  = 13'b0000010100001;
    localparam logic [12:0] C_JALR = 13'b0000010101001;

    typedef struct {
        logic [15:0] instr;
        logic        ack;
        logic        zero;
        logic [12:0] ctrl;
        logic        chk;
        logic [3:0]  inst;
        logic [1:0]  si;
        logic        ill;
    } vec_t;

    vec_t vq[$];
    logic zero_v;
    logic ill_v;
    int   n_checks;
    int   n_errors;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] instr, input logic ack, input logic [12:0] c);
        vec_t v;
        v.instr = instr; v.ack = ack; v.zero = zero_v; v.ctrl = c;
        v.chk = 1'b0; v.inst = 4'h0; v.si = 2'b00; v.ill = ill_v;
        vq.push_back(v);
    endtask

    task automatic push_i(input logic [15:0] instr, input logic ack, input logic [12:0] c);
        vec_t v;
        v.instr = instr; v.ack = ack; v.zero = zero_v; v.ctrl = c;
        v.chk = 1'b1; v.inst = instr[15:12]; v.si = instr[1:0]; v.ill = ill_v;
        vq.push_back(v);
    endtask

    // Plain ALU op, ack tied high: FETCH, DECODE, EXEC, ALU_WB.
    task automatic alu(input logic [15:0] instr, input logic imm);
        push(instr, 1'b1, C_FA);
        push(instr, 1'b1, C_DEC);
        push_i(instr, 1'b1, imm ? C_EXI : C_EXR);
        push_i(instr, 1'b1, C_AWB);
    endtask

    task automatic run_vecs(input string name);
        int n;
        n = vq.size();
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            In_Instr  = vq[i].instr;
            In_MemAck = vq[i].ack;
            In_Zero   = vq[i].zero;
            #1;
            check($sformatf("%s.c%0d.ctrl", name, i), {3'b0, ctrl}, {3'b0, vq[i].ctrl});
            check($sformatf("%s.c%0d.illegal", name, i), {15'b0, Out_Illegal}, {15'b0, vq[i].ill});
            if (vq[i].chk) begin
                check($sformatf("%s.c%0d.inst", name, i), {12'b0, Out_Inst}, {12'b0, vq[i].inst});
                check($sformatf("%s.c%0d.si", name, i), {14'b0, Out_Si}, {14'b0, vq[i].si});
            end
        end
        vq.delete();
        $display("[tb] %-12s %0d cycles  checks=%0d errors=%0d", name, n, n_checks, n_errors);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ctrl"}, {3'b0, ctrl}, {3'b0, C_IDLE});
        check({tag, ".inst"}, {12'b0, Out_Inst}, 16'h0000);
        check({tag, ".si"}, {14'b0, Out_Si}, 16'h0000);
        check({tag, ".illegal"}, {15'b0, Out_Illegal}, 16'h0000);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        zero_v    = 1'b0;
        ill_v     = 1'b0;
        In_Instr  = 16'h5003;
        In_MemAck = 1'b1;
        In_Zero   = 1'b0;
        Reset_N   = 1'b1;
        #1 Reset_N = 1'b0;

        // Held in reset with ack high and a live instruction: nothing moves.
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            check_reset_outputs($sformatf("reset.c%0d", i));
        end
        @(posedge CLK);
        #2 Reset_N = 1'b1;

        push(16'h0000, 1'b1, C_IDLE);
        run_vecs("init");

        alu(16'h0000, 1'b0);
        run_vecs("add");

        // LW with the data ack three cycles late.
        push(16'h7000, 1'b1, C_FA);
        push(16'h7000, 1'b0, C_DEC);
        push_i(16'h7000, 1'b0, C_ADDR);
        push_i(16'h7000, 1'b0, C_MRD);
        push_i(16'h7000, 1'b0, C_MRD);
        push_i(16'h7000, 1'b0, C_MRD);
        push_i(16'h7000, 1'b1, C_MRD);
        push_i(16'h7000, 1'b0, C_MWB);
        run_vecs("lw");

        push(16'h8001, 1'b1, C_FA);
        push(16'h8001, 1'b1, C_DEC);
        push_i(16'h8001, 1'b1, C_ADDR);
        push_i(16'h8001, 1'b1, C_MWR);
        run_vecs("sw");

        for (int z = 0; z < 2; z++) begin
            zero_v = z[0];
            push(16'h9002, 1'b1, C_FA);
            push(16'h9002, 1'b1, C_DEC);
            push_i(16'h9002, 1'b1, C_BR);
            run_vecs(z == 0 ? "beq_z0" : "beq_z1");
        end
        zero_v = 1'b0;

        alu(16'h5003, 1'b0);
        run_vecs("shift");
        alu(16'h4000, 1'b1);
        run_vecs("addi");
        alu(16'hF001, 1'b1);
        run_vecs("lbi");

        push(16'hC000, 1'b1, C_FA);
        push(16'hC000, 1'b1, C_DEC);
        push_i(16'hC000, 1'b1, C_JAL);
        run_vecs("jal");
        push(16'hD000, 1'b1, C_FA);
        push(16'hD000, 1'b1, C_DEC);
        push_i(16'hD000, 1'b1, C_JALR);
        run_vecs("jalr");

        // Instruction fetch waits two cycles before the ack.
        push(16'h3002, 1'b0, C_FW);
        push(16'h3002, 1'b0, C_FW);
        push(16'h3002, 1'b1, C_FA);
        push(16'h3002, 1'b1, C_DEC);
        push_i(16'h3002, 1'b1, C_EXR);
        push_i(16'h3002, 1'b1, C_AWB);
        run_vecs("or_wait");

        push(16'hA000, 1'b1, C_FA);
        push(16'hA000, 1'b1, C_DEC);
`ifdef CONTROL_ILLEGAL_TRAP_EN
        ill_v = 1'b1;
        for (int i = 0; i < 4; i++) push(16'h0000, 1'b1, C_IDLE);
        ill_v = 1'b0;
`else
        alu(16'h1000, 1'b0);
`endif
        run_vecs("illegal");

        // Asynchronous reset in the middle of a stalled store.
        @(negedge CLK);
        Reset_N = 1'b0;
        #1;
        @(posedge CLK);
        #2 Reset_N = 1'b1;
        push(16'h8000, 1'b1, C_IDLE);
        push(16'h8000, 1'b1, C_FA);
        push(16'h8000, 1'b1, C_DEC);
        push_i(16'h8000, 1'b0, C_ADDR);
        push_i(16'h8000, 1'b0, C_MWR);
        push_i(16'h8000, 1'b0, C_MWR);
        run_vecs("sw_stall");
        #1 Reset_N = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            In_MemAck = 1'b1;
            #1;
            check_reset_outputs($sformatf("rst_hold.c%0d", i));
        end
        @(posedge CLK);
        #2 Reset_N = 1'b1;
        push(16'h0000, 1'b1, C_IDLE);
        alu(16'h0000, 1'b0);
        run_vecs("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
